// File: rtl/sysid_ctrl_pkg.sv
// Shared types and constants for the sysid boot checker: FSM state encoding,
// Avalon word addresses, default expected words and the sticky status bundle.
package sysid_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_ID,
        RD_TS,
        CMP
    } sysid_state_e;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] SYSID_EXP_ID_DEFAULT = 32'd0;
    localparam logic [31:0] SYSID_EXP_TS_DEFAULT = 32'd1493910150;

    typedef struct packed {
        logic done;
        logic match;
        logic id_ok;
        logic ts_ok;
        logic timeout_err;
    } sysid_flags_t;

endpackage

// File: rtl/sysid_verify_ctrl_wait_timer.sv
// Saturating count of consecutive waitrequest cycles for the current read;
// expired is high once TIMEOUT-1 stalls have been seen. Shared by both read states.
module sysid_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == LAST);

endmodule

// File: rtl/sysid_verify_ctrl.sv
// Boot-time sysid checker: reads the ID word (addr 0) then the timestamp (addr 1)
// as an Avalon-MM master and posts sticky status. Optional macro SYSID_PERIODIC_EN.
module sysid_verify_ctrl
    import sysid_ctrl_pkg::*;
#(
    parameter logic [31:0] EXP_ID  = SYSID_EXP_ID_DEFAULT,
    parameter logic [31:0] EXP_TS  = SYSID_EXP_TS_DEFAULT,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned PERIOD  = 1024
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        match,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    sysid_state_e r_state, w_state_nxt;
    logic         r_avm_read, w_read_nxt;
    logic         r_avm_address, w_addr_nxt;
    logic         r_busy, w_busy_nxt;
    sysid_flags_t r_flags, w_flags_nxt;
    logic [31:0]  r_id_value, w_id_nxt;
    logic [31:0]  r_ts_value, w_ts_nxt;

    logic w_reading;
    logic w_accept;
    logic w_launch;
    logic w_expired;

    assign w_reading = (r_state == RD_ID) || (r_state == RD_TS);
    assign w_accept  = w_reading && !avm_waitrequest;

`ifdef SYSID_PERIODIC_EN
    localparam int unsigned PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [PW-1:0] r_period_cnt;
    logic          w_period_fire;

    // Only counts while idle with a completed result on display.
    assign w_period_fire = (r_state == IDLE) && r_flags.done &&
                           (r_period_cnt == PW'(PERIOD - 1));
    assign w_launch      = (r_state == IDLE) && (start || w_period_fire);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_period_cnt <= '0;
        end else if (w_launch) begin
            r_period_cnt <= '0;
        end else if ((r_state == IDLE) && r_flags.done) begin
            r_period_cnt <= r_period_cnt + 1'b1;
        end
    end
`else
    assign w_launch = (r_state == IDLE) && start;
`endif

    sysid_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_clear   (w_launch || w_accept),
        .i_enable  (w_reading && avm_waitrequest),
        .o_expired (w_expired)
    );

    always_comb begin
        // NOTE: every next-value signal starts from its held value so no path leaves one unassigned (no latch).
        w_state_nxt = r_state;
        w_read_nxt  = r_avm_read;
        w_addr_nxt  = r_avm_address;
        w_busy_nxt  = r_busy;
        w_flags_nxt = r_flags;
        w_id_nxt    = r_id_value;
        w_ts_nxt    = r_ts_value;

        case (r_state)
            IDLE: begin
                if (w_launch) begin
                    w_state_nxt = RD_ID;
                    w_read_nxt  = 1'b1;
                    w_addr_nxt  = SYSID_ADDR_ID;
                    w_busy_nxt  = 1'b1;
                    w_flags_nxt = '0;
                end
            end
            RD_ID, RD_TS: begin
                if (w_accept) begin
                    if (r_state == RD_ID) begin
                        w_id_nxt    = avm_readdata;
                        w_addr_nxt  = SYSID_ADDR_TS;
                        w_state_nxt = RD_TS;
                    end else begin
                        w_ts_nxt    = avm_readdata;
                        w_read_nxt  = 1'b0;
                        w_addr_nxt  = SYSID_ADDR_ID;
                        w_state_nxt = CMP;
                    end
                end else if (w_expired) begin
                    // Slave stalled too long: abandon the sequence, id_ok/ts_ok/match stay 0.
                    w_read_nxt              = 1'b0;
                    w_addr_nxt              = SYSID_ADDR_ID;
                    w_busy_nxt              = 1'b0;
                    w_flags_nxt.done        = 1'b1;
                    w_flags_nxt.timeout_err = 1'b1;
                    w_state_nxt             = IDLE;
                end
            end
            CMP: begin
                w_flags_nxt.id_ok = (r_id_value == EXP_ID);
                w_flags_nxt.ts_ok = (r_ts_value == EXP_TS);
                w_flags_nxt.match = (r_id_value == EXP_ID) && (r_ts_value == EXP_TS);
                w_flags_nxt.done  = 1'b1;
                w_busy_nxt        = 1'b0;
                w_state_nxt       = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: non-blocking so every register samples the pre-edge values; reset is checked on the edge.
        if (!reset_n) begin
            r_state       <= IDLE;
            r_avm_read    <= 1'b0;
            r_avm_address <= SYSID_ADDR_ID;
            r_busy        <= 1'b0;
            r_flags       <= '0;
            r_id_value    <= '0;
            r_ts_value    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_avm_read    <= w_read_nxt;
            r_avm_address <= w_addr_nxt;
            r_busy        <= w_busy_nxt;
            r_flags       <= w_flags_nxt;
            r_id_value    <= w_id_nxt;
            r_ts_value    <= w_ts_nxt;
        end
    end

    assign avm_read    = r_avm_read;
    assign avm_address = r_avm_address;
    assign busy        = r_busy;
    assign done        = r_flags.done;
    assign match       = r_flags.match;
    assign id_ok       = r_flags.id_ok;
    assign ts_ok       = r_flags.ts_ok;
    assign timeout_err = r_flags.timeout_err;
    assign id_value    = r_id_value;
    assign ts_value    = r_ts_value;

endmodule

// File: tb/tb_sysid_verify_ctrl.sv
// Self-checking bench for sysid_verify_ctrl: reactive sysid slave, timeline model
// of each check, per-cycle comparison plus hand-computed latency/result literals.
module tb_sysid_verify_ctrl;

    localparam int T = 16;
    localparam int P = 8;
    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1493910150;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        busy, done, match, id_ok, ts_ok, timeout_err;
    logic [31:0] id_value, ts_value;

    sysid_verify_ctrl #(
        .EXP_ID  (EXP_ID),
        .EXP_TS  (EXP_TS),
        .TIMEOUT (T),
        .PERIOD  (P)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .busy            (busy),
        .done            (done),
        .match           (match),
        .id_ok           (id_ok),
        .ts_ok           (ts_ok),
        .timeout_err     (timeout_err),
        .id_value        (id_value),
        .ts_value        (ts_value)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit cmp_en   = 1'b0;

    // Slave behaviour: stall cycles and data word per address.
    int          stall_cfg [2];
    logic [31:0] data_cfg  [2];

    int rd_cycles = 0;
    int rd_addr1  = 0;
    int launches  = 0;
    bit prev_read = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0d (0x%0h) expected %0d (0x%0h)", name, cyc, act, act, exp, exp);
        end
    endtask

    // ---------------- timeline model of one check ----------------
    bit          m_active = 1'b0;
    int          m_L, m_edone, m_rd0_last, m_rd1_first, m_rd1_last, m_cap_id, m_cap_ts;
    logic [31:0] m_id_new, m_ts_new;
    logic [31:0] m_id_prev = '0;
    logic [31:0] m_ts_prev = '0;
    logic [4:0]  m_fin;    // {done, match, id_ok, ts_ok, timeout_err}

    task automatic model_launch(input int e);
        bit iok, tok;
        if (m_active) begin
            if (m_cap_id >= 0) m_id_prev = m_id_new;
            if (m_cap_ts >= 0) m_ts_prev = m_ts_new;
        end
        m_active    = 1'b1;
        m_L         = e;
        m_cap_id    = -1;
        m_cap_ts    = -1;
        m_rd1_first = -1;
        m_rd1_last  = -1;
        if (stall_cfg[0] >= T) begin
            m_rd0_last = e + T - 1;
            m_edone    = e + T;
            m_fin      = 5'b10001;
        end else begin
            m_rd0_last  = e + stall_cfg[0];
            m_cap_id    = m_rd0_last + 1;
            m_id_new    = data_cfg[0];
            m_rd1_first = m_cap_id;
            if (stall_cfg[1] >= T) begin
                m_rd1_last = m_rd1_first + T - 1;
                m_edone    = m_rd1_first + T;
                m_fin      = 5'b10001;
            end else begin
                m_rd1_last = m_rd1_first + stall_cfg[1];
                m_cap_ts   = m_rd1_last + 1;
                m_ts_new   = data_cfg[1];
                m_edone    = m_cap_ts + 1;
                iok        = (data_cfg[0] == EXP_ID);
                tok        = (data_cfg[1] == EXP_TS);
                m_fin      = {1'b1, iok && tok, iok, tok, 1'b0};
            end
        end
    endtask

    initial forever begin
        bit auto_fire;
        @(posedge clock);
        cyc++;
`ifdef SYSID_PERIODIC_EN
        auto_fire = m_active && (cyc == m_edone + P);
`else
        auto_fire = 1'b0;
`endif
        if (!reset_n) begin
            m_active  = 1'b0;
            m_id_prev = '0;
            m_ts_prev = '0;
        end else if ((!m_active || cyc > m_edone) && (start || auto_fire)) begin
            model_launch(cyc);
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        int          e;
        bit          eb, er, ea;
        logic [31:0] eid, ets;
        logic [4:0]  ef;
        @(negedge clock);
        if (cmp_en) begin
            e   = cyc;
            eb  = 1'b0;
            er  = 1'b0;
            ea  = 1'b0;
            eid = m_id_prev;
            ets = m_ts_prev;
            ef  = '0;
            if (m_active) begin
                eb = (e >= m_L) && (e < m_edone);
                if (e >= m_L && e <= m_rd0_last) er = 1'b1;
                if (m_rd1_first >= 0 && e >= m_rd1_first && e <= m_rd1_last) begin
                    er = 1'b1;
                    ea = 1'b1;
                end
                if (m_cap_id >= 0 && e >= m_cap_id) eid = m_id_new;
                if (m_cap_ts >= 0 && e >= m_cap_ts) ets = m_ts_new;
                if (e >= m_edone) ef = m_fin;
            end
            check("cyc_busy", busy, eb);
            check("cyc_avm_read", avm_read, er);
            if (er) check("cyc_avm_address", avm_address, ea);
            check("cyc_id_value", id_value, eid);
            check("cyc_ts_value", ts_value, ets);
            check("cyc_flags", {done, match, id_ok, ts_ok, timeout_err}, ef);
        end
    end

    // ---------------- sysid slave ----------------
    initial begin
        int cnt [2];
        cnt[0]          = 0;
        cnt[1]          = 0;
        avm_waitrequest = 1'b0;
        avm_readdata    = 32'hDEAD_BEEF;
        forever begin
            @(negedge clock);
            if (avm_read !== 1'b1) begin
                cnt[0]          = 0;
                cnt[1]          = 0;
                avm_waitrequest = 1'b0;
                avm_readdata    = 32'hDEAD_BEEF;
            end else if (cnt[avm_address] < stall_cfg[avm_address]) begin
                cnt[avm_address]++;
                avm_waitrequest = 1'b1;
                avm_readdata    = 32'hDEAD_BEEF;
            end else begin
                avm_waitrequest = 1'b0;
                avm_readdata    = data_cfg[avm_address];
            end
        end
    end

    // Read-activity monitor.
    initial forever begin
        @(negedge clock);
        if (avm_read === 1'b1) begin
            rd_cycles++;
            if (avm_address === 1'b1) rd_addr1++;
            if (!prev_read) launches++;
        end
        prev_read = (avm_read === 1'b1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse_start(output int le);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        le = cyc;
    endtask

    task automatic wait_done(input int le, output int lat);
        bit seen = 1'b0;
        lat = -1;
        for (int k = 0; k < 64 && !seen; k++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                seen = 1'b1;
                lat  = cyc - le;
            end
        end
        if (!seen) check("done_wait_expired", 32'd0, 32'd1);
    endtask

    task automatic run_check(input int s0, input int s1, input logic [31:0] d0, input logic [31:0] d1,
                             output int lat, output int rd, output int a1, output int ln);
        int le, rd0, a10, ln0;
        stall_cfg[0] = s0;
        stall_cfg[1] = s1;
        data_cfg[0]  = d0;
        data_cfg[1]  = d1;
        rd0 = rd_cycles;
        a10 = rd_addr1;
        ln0 = launches;
        pulse_start(le);
        wait_done(le, lat);
        rd = rd_cycles - rd0;
        a1 = rd_addr1 - a10;
        ln = launches - ln0;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int lat, rd, a1, ln, le, ln0, rd0, edone_seen, rise;
        bit seen;
        reset_n      = 1'b0;
        start        = 1'b0;
        stall_cfg[0] = 0;
        stall_cfg[1] = 0;
        data_cfg[0]  = EXP_ID;
        data_cfg[1]  = EXP_TS;
        repeat (3) @(negedge clock);
        check("rst_avm_read", avm_read, 0);
        check("rst_avm_address", avm_address, 0);
        check("rst_busy", busy, 0);
        check("rst_flags", {done, match, id_ok, ts_ok, timeout_err}, 0);
        check("rst_id_value", id_value, 0);
        check("rst_ts_value", ts_value, 0);
        cmp_en  = 1'b1;
        reset_n = 1'b1;
        @(negedge clock);

        // Nominal.
        run_check(0, 0, EXP_ID, EXP_TS, lat, rd, a1, ln);
        check("nom_latency", lat, 3);
        check("nom_read_cycles", rd, 2);
        check("nom_match", match, 1);
        check("nom_id_ok", id_ok, 1);
        check("nom_ts_ok", ts_ok, 1);
        check("nom_ts_value", ts_value, 32'd1493910150);

        // Timestamp mismatch by one.
        run_check(0, 0, EXP_ID, 32'd1493910151, lat, rd, a1, ln);
        check("mis_done", done, 1);
        check("mis_id_ok", id_ok, 1);
        check("mis_ts_ok", ts_ok, 0);
        check("mis_match", match, 0);
        check("mis_timeout", timeout_err, 0);
        check("mis_ts_value", ts_value, 32'd1493910151);

        // Three stall cycles on the timestamp read.
        run_check(0, 3, EXP_ID, EXP_TS, lat, rd, a1, ln);
        check("stall_latency", lat, 6);
        check("stall_read_cycles", rd, 5);
        check("stall_addr1_cycles", a1, 4);
        check("stall_match", match, 1);

        // Stall one short of the limit still completes.
        run_check(T - 1, 0, EXP_ID, EXP_TS, lat, rd, a1, ln);
        check("edge_latency", lat, 18);
        check("edge_timeout", timeout_err, 0);
        check("edge_match", match, 1);

        // ID read stuck in waitrequest.
        run_check(100, 0, EXP_ID, EXP_TS, lat, rd, a1, ln);
        check("to_latency", lat, 16);
        check("to_read_cycles", rd, 16);
        check("to_addr1_cycles", a1, 0);
        check("to_timeout_err", timeout_err, 1);
        check("to_busy", busy, 0);
        check("to_match", match, 0);
        check("to_id_ok", id_ok, 0);

        // Second start during the timestamp read is dropped.
        stall_cfg[0] = 0;
        stall_cfg[1] = 2;
        ln0 = launches;
        rd0 = rd_cycles;
        pulse_start(le);
        @(negedge clock);
        check("busy_in_rd_ts", avm_address, 1);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done(le, lat);
        repeat (3) @(negedge clock);
        check("busy_latency", lat, 5);
        check("busy_launches", launches - ln0, 1);
        check("busy_read_cycles", rd_cycles - rd0, 4);

        // Reset in the middle of the ID read.
        stall_cfg[0] = 5;
        stall_cfg[1] = 0;
        pulse_start(le);
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        check("midrst_avm_read", avm_read, 0);
        check("midrst_busy", busy, 0);
        check("midrst_flags", {done, match, id_ok, ts_ok, timeout_err}, 0);
        check("midrst_ts_value", ts_value, 0);
        reset_n = 1'b1;
        @(negedge clock);
        run_check(0, 0, EXP_ID, EXP_TS, lat, rd, a1, ln);
        check("post_rst_latency", lat, 3);
        check("post_rst_match", match, 1);
        edone_seen = cyc;

`ifdef SYSID_PERIODIC_EN
        // Automatic re-check PERIOD cycles after completion.
        seen = 1'b0;
        rise = -1;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clock);
            if (avm_read === 1'b1) begin
                seen = 1'b1;
                rise = cyc;
            end
        end
        check("per_relaunch_delay", rise - edone_seen, 8);
        wait_done(rise, lat);
        check("per_latency", lat, 3);
        check("per_match", match, 1);
`else
        // Without the periodic feature nothing relaunches on its own.
        ln0  = launches;
        seen = 1'b0;
        rise = 0;
        repeat (20) @(negedge clock);
        check("noper_launches", launches - ln0, rise);
        check("noper_done_held", done, 1);
`endif

        repeat (2) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
